// File: rtl/shop_cmd_framer.sv
// Packs LF-terminated ASCII command lines into MSB-first words and streams them to the shop core.
// Optional: define SHOP_FRAMER_CR_STRIP_EN to silently consume CR (8'h0D) bytes.
`timescale 1ns/1ps
module shop_cmd_framer #(
    parameter int          O_A_NUM_BITS = 24,
    parameter int          O_U_NUM_BITS = 4,
    parameter int          MAX_WORDS    = 4,
    parameter logic [7:0]  PAD_CHAR     = 8'h20
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    input  logic [7:0]              i_byte,
    input  logic [O_U_NUM_BITS-1:0] i_uid,
    input  logic                    i_hold,
    output logic                    o_ready,
    output logic                    o_rdy,
    output logic [O_U_NUM_BITS-1:0] o_u,
    output logic [O_A_NUM_BITS-1:0] o_a,
    output logic                    o_last,
    output logic                    o_err
);
    localparam int CPW = O_A_NUM_BITS / 8;
    localparam int CW  = (CPW > 1) ? $clog2(CPW) : 1;
    localparam int WW  = $clog2(MAX_WORDS + 1);
    localparam int AW  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DROP, EMIT} state_t;

    state_t                    state_reg;
    logic [O_A_NUM_BITS-1:0]   word_reg;
    logic [CW-1:0]             ccnt_reg;
    logic [WW-1:0]             wcnt_reg;
    logic [WW-1:0]             idx_reg;
    logic [O_U_NUM_BITS-1:0]   uid_reg;
    logic [O_A_NUM_BITS-1:0]   buffer_reg [MAX_WORDS];

    logic [O_A_NUM_BITS-1:0]   pad_word;
    logic [O_A_NUM_BITS-1:0]   word_put;
    logic [O_A_NUM_BITS-1:0]   first_word;
    logic [WW-1:0]             total_words;
    logic                      accept;
    logic                      is_lf;
    logic                      is_cr;

    // Slot 0 sits in the top byte so characters read left to right in the word.
    for (genvar gi = 0; gi < CPW; gi++) begin : g_slot
        assign pad_word[gi*8 +: 8] = PAD_CHAR;
        assign word_put[gi*8 +: 8] = (ccnt_reg == CW'(CPW-1-gi)) ? i_byte : word_reg[gi*8 +: 8];
    end

    assign accept      = i_valid && o_ready;
    assign is_lf       = (i_byte == 8'h0A);
`ifdef SHOP_FRAMER_CR_STRIP_EN
    assign is_cr       = (i_byte == 8'h0D);
`else
    assign is_cr       = 1'b0;
`endif
    assign total_words = (ccnt_reg != '0) ? wcnt_reg + WW'(1) : wcnt_reg;
    // A line shorter than one word has nothing in the buffer yet; its padded word is still in word_reg.
    assign first_word  = (wcnt_reg == '0) ? word_reg : buffer_reg[0];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= IDLE;
            word_reg  <= pad_word;
            ccnt_reg  <= '0;
            wcnt_reg  <= '0;
            idx_reg   <= '0;
            uid_reg   <= '0;
            o_ready   <= 1'b0;
            o_rdy     <= 1'b0;
            o_u       <= '0;
            o_a       <= '0;
            o_last    <= 1'b0;
            o_err     <= 1'b0;
            for (int i = 0; i < MAX_WORDS; i++) buffer_reg[i] <= '0;
        end else begin
            o_rdy  <= 1'b0;
            o_last <= 1'b0;
            o_err  <= 1'b0;
            case (state_reg)
                IDLE, COLLECT: begin
                    o_ready <= 1'b1;
                    if (accept && !is_cr) begin
                        if (is_lf) begin
                            if (state_reg == COLLECT) begin
                                if (ccnt_reg != '0) buffer_reg[wcnt_reg[AW-1:0]] <= word_reg;
                                wcnt_reg  <= total_words;
                                ccnt_reg  <= '0;
                                word_reg  <= pad_word;
                                o_ready   <= 1'b0;
                                state_reg <= EMIT;
                                idx_reg   <= '0;
                                // The first beat leaves on the same edge that takes the LF.
                                if (!i_hold) begin
                                    o_rdy  <= 1'b1;
                                    o_a    <= first_word;
                                    o_u    <= uid_reg;
                                    o_last <= (total_words == WW'(1));
                                    if (total_words == WW'(1)) begin
                                        wcnt_reg  <= '0;
                                        state_reg <= IDLE;
                                    end else begin
                                        idx_reg <= WW'(1);
                                    end
                                end
                            end
                        end else if (wcnt_reg == WW'(MAX_WORDS)) begin
                            state_reg <= DROP;
                        end else begin
                            if (state_reg == IDLE) uid_reg <= i_uid;
                            state_reg <= COLLECT;
                            if (ccnt_reg == CW'(CPW-1)) begin
                                buffer_reg[wcnt_reg[AW-1:0]] <= word_put;
                                wcnt_reg <= wcnt_reg + WW'(1);
                                ccnt_reg <= '0;
                                word_reg <= pad_word;
                            end else begin
                                word_reg <= word_put;
                                ccnt_reg <= ccnt_reg + CW'(1);
                            end
                        end
                    end
                end
                DROP: begin
                    o_ready <= 1'b1;
                    if (accept && is_lf) begin
                        o_err     <= 1'b1;
                        word_reg  <= pad_word;
                        ccnt_reg  <= '0;
                        wcnt_reg  <= '0;
                        state_reg <= IDLE;
                    end
                end
                EMIT: begin
                    o_ready <= 1'b0;
                    if (!i_hold) begin
                        o_rdy  <= 1'b1;
                        o_a    <= buffer_reg[idx_reg[AW-1:0]];
                        o_u    <= uid_reg;
                        o_last <= (idx_reg == wcnt_reg - WW'(1));
                        if (idx_reg == wcnt_reg - WW'(1)) begin
                            idx_reg   <= '0;
                            wcnt_reg  <= '0;
                            state_reg <= IDLE;
                        end else begin
                            idx_reg <= idx_reg + WW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shop_cmd_framer.sv
// Directed bench for shop_cmd_framer: one task per scenario, beats collected by a negedge monitor.
`timescale 1ns/1ps
module tb_shop_cmd_framer;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic [3:0]  i_uid = 4'd0;
    logic        i_hold = 1'b0;
    logic        o_ready, o_rdy, o_last, o_err;
    logic [3:0]  o_u;
    logic [23:0] o_a;

    shop_cmd_framer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_byte(i_byte),
        .i_uid(i_uid), .i_hold(i_hold), .o_ready(o_ready), .o_rdy(o_rdy),
        .o_u(o_u), .o_a(o_a), .o_last(o_last), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [23:0] a;
        logic [3:0]  u;
        logic        last;
        int          cyc;
    } beat_t;

    int    cyc = 0;
    beat_t q[$];
    int    err_cnt = 0;
    int    err_cyc = 0;
    int    lf_cyc = 0;
    int    pass_cnt = 0;
    int    total_cnt = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_rdy === 1'b1) begin
            q.push_back('{a: o_a, u: o_u, last: o_last, cyc: cyc});
            $display("beat cyc=%0d a=%h u=%0d last=%0b", cyc, o_a, o_u, o_last);
        end
        if (o_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
            $display("err pulse cyc=%0d", cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        i_valid = 1'b1;
        i_byte  = b;
        while (o_ready !== 1'b1 && t < 40) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 40) begin
            total_cnt++;
            $display("FAIL send_timeout byte=%h o_ready=%b required 1", b, o_ready);
        end
        @(posedge i_clk);
        #1 lf_cyc = cyc;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        total_cnt++;
        if ({o_rdy, o_a, o_u, o_last, o_err, o_ready} !== 32'd0)
            $display("FAIL reset_outputs got=%h required 0", {o_rdy, o_a, o_u, o_last, o_err, o_ready});
        else pass_cnt++;
        i_reset = 1'b1;
        @(negedge i_clk);
        total_cnt++;
        if (o_ready !== 1'b1) $display("FAIL reset_ready got=%b required 1", o_ready);
        else pass_cnt++;
    endtask

    task automatic test_login();
        int base = q.size();
        int e0 = err_cnt;
        int nb;
        i_uid = 4'd2;
        send_str("Login");
        send_byte(8'h0A);
        repeat (6) @(negedge i_clk);
        nb = q.size() - base;
        total_cnt++;
        if (err_cnt !== e0) $display("FAIL login_err got=%0d required %0d", err_cnt, e0);
        else pass_cnt++;
        total_cnt++;
        if (nb !== 2) begin
            $display("FAIL login_count got=%0d required 2", nb);
            return;
        end
        pass_cnt++;
        total_cnt++;
        if ({q[base].a, q[base].u, q[base].last} !== {24'h4C6F67, 4'd2, 1'b0})
            $display("FAIL login_w0 got=%h/%0d/%0b required 4c6f67/2/0", q[base].a, q[base].u, q[base].last);
        else pass_cnt++;
        total_cnt++;
        if ({q[base+1].a, q[base+1].u, q[base+1].last} !== {24'h696E20, 4'd2, 1'b1})
            $display("FAIL login_w1 got=%h/%0d/%0b required 696e20/2/1", q[base+1].a, q[base+1].u, q[base+1].last);
        else pass_cnt++;
        total_cnt++;
        if (q[base].cyc !== lf_cyc) $display("FAIL login_latency got=%0d required %0d", q[base].cyc, lf_cyc);
        else pass_cnt++;
        total_cnt++;
        if (q[base+1].cyc !== lf_cyc + 1) $display("FAIL login_b2b got=%0d required %0d", q[base+1].cyc, lf_cyc + 1);
        else pass_cnt++;
    endtask

    task automatic test_boundary();
        logic [23:0] exp_w [4];
        int base, nb;
        exp_w[0] = 24'h414243; exp_w[1] = 24'h444546; exp_w[2] = 24'h474849; exp_w[3] = 24'h4A4B4C;
        base = q.size();
        i_uid = 4'd3;
        send_str("Buy");
        send_byte(8'h0A);
        repeat (5) @(negedge i_clk);
        nb = q.size() - base;
        total_cnt++;
        if (nb !== 1) $display("FAIL buy_count got=%0d required 1", nb);
        else pass_cnt++;
        total_cnt++;
        if (nb >= 1 && {q[base].a, q[base].u, q[base].last} !== {24'h427579, 4'd3, 1'b1})
            $display("FAIL buy_word got=%h/%0d/%0b required 427579/3/1", q[base].a, q[base].u, q[base].last);
        else if (nb >= 1) pass_cnt++;
        else $display("FAIL buy_word got=none required 427579/3/1");
        base = q.size();
        send_byte(8'h0A);
        repeat (5) @(negedge i_clk);
        total_cnt++;
        if (q.size() - base !== 0) $display("FAIL empty_line got=%0d beats required 0", q.size() - base);
        else pass_cnt++;
        total_cnt++;
        if (o_ready !== 1'b1) $display("FAIL empty_ready got=%b required 1", o_ready);
        else pass_cnt++;
        base = q.size();
        i_uid = 4'd1;
        send_str("ABCDEFGHIJKL");
        send_byte(8'h0A);
        repeat (8) @(negedge i_clk);
        nb = q.size() - base;
        total_cnt++;
        if (nb !== 4) begin
            $display("FAIL full_count got=%0d required 4", nb);
            return;
        end
        pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if ({q[base+k].a, q[base+k].u, q[base+k].last} !== {exp_w[k], 4'd1, (k == 3)})
                $display("FAIL full_w%0d got=%h/%0d/%0b required %h/1/%0b", k,
                         q[base+k].a, q[base+k].u, q[base+k].last, exp_w[k], (k == 3));
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        int base = q.size();
        int e0 = err_cnt;
        int nb;
        i_uid = 4'd4;
        send_str("AddItemAddItem");
        send_byte(8'h0A);
        repeat (5) @(negedge i_clk);
        total_cnt++;
        if (q.size() - base !== 0) $display("FAIL ovf_beats got=%0d required 0", q.size() - base);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt - e0 !== 1) $display("FAIL ovf_err_count got=%0d required 1", err_cnt - e0);
        else pass_cnt++;
        total_cnt++;
        if (err_cyc !== lf_cyc) $display("FAIL ovf_err_cycle got=%0d required %0d", err_cyc, lf_cyc);
        else pass_cnt++;
        base = q.size();
        i_uid = 4'd6;
        send_str("Adm");
        send_byte(8'h0A);
        repeat (5) @(negedge i_clk);
        nb = q.size() - base;
        total_cnt++;
        if (nb !== 1) $display("FAIL adm_count got=%0d required 1", nb);
        else if ({q[base].a, q[base].u, q[base].last} !== {24'h41646D, 4'd6, 1'b1})
            $display("FAIL adm_word got=%h/%0d/%0b required 41646d/6/1", q[base].a, q[base].u, q[base].last);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        int base = q.size();
        int nb, rel_cyc;
        i_uid = 4'd5;
        send_byte("D");
        i_uid = 4'd9;
        send_str("elUsr");
        i_hold = 1'b1;
        send_byte(8'h0A);
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (o_rdy !== 1'b0 || o_ready !== 1'b0)
                $display("FAIL hold_quiet%0d got rdy=%b ready=%b required 0/0", k, o_rdy, o_ready);
            else pass_cnt++;
            if (k < 2) @(negedge i_clk);
        end
        rel_cyc = cyc;
        i_hold = 1'b0;
        repeat (6) @(negedge i_clk);
        nb = q.size() - base;
        total_cnt++;
        if (nb !== 2) begin
            $display("FAIL hold_count got=%0d required 2", nb);
            return;
        end
        pass_cnt++;
        total_cnt++;
        if ({q[base].a, q[base].u, q[base].last} !== {24'h44656C, 4'd5, 1'b0})
            $display("FAIL hold_w0 got=%h/%0d/%0b required 44656c/5/0", q[base].a, q[base].u, q[base].last);
        else pass_cnt++;
        total_cnt++;
        if ({q[base+1].a, q[base+1].u, q[base+1].last} !== {24'h557372, 4'd5, 1'b1})
            $display("FAIL hold_w1 got=%h/%0d/%0b required 557372/5/1", q[base+1].a, q[base+1].u, q[base+1].last);
        else pass_cnt++;
        total_cnt++;
        if (q[base].cyc !== rel_cyc + 1 || q[base+1].cyc !== rel_cyc + 2)
            $display("FAIL hold_timing got=%0d,%0d required %0d,%0d", q[base].cyc, q[base+1].cyc, rel_cyc + 1, rel_cyc + 2);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_emit();
        int base;
        i_uid = 4'd7;
        send_str("Logout");
        send_byte(8'h0A);
        total_cnt++;
        if (o_rdy !== 1'b1 || o_a !== 24'h4C6F67)
            $display("FAIL rst_first_beat got rdy=%b a=%h required 1/4c6f67", o_rdy, o_a);
        else pass_cnt++;
        i_reset = 1'b0;
        #1;
        base = q.size();
        total_cnt++;
        if ({o_rdy, o_a, o_u, o_last, o_err, o_ready} !== 32'd0)
            $display("FAIL rst_async got=%h required 0", {o_rdy, o_a, o_u, o_last, o_err, o_ready});
        else pass_cnt++;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        repeat (6) @(negedge i_clk);
        total_cnt++;
        if (q.size() - base !== 0) $display("FAIL rst_no_tail got=%0d beats required 0", q.size() - base);
        else pass_cnt++;
        total_cnt++;
        if (o_ready !== 1'b1) $display("FAIL rst_ready got=%b required 1", o_ready);
        else pass_cnt++;
    endtask

    task automatic test_cr();
        int base = q.size();
        int nb;
        i_uid = 4'd8;
        send_str("Buy");
        send_byte(8'h0D);
        send_byte(8'h0A);
        repeat (6) @(negedge i_clk);
        nb = q.size() - base;
`ifdef SHOP_FRAMER_CR_STRIP_EN
        total_cnt++;
        if (nb !== 1) $display("FAIL cr_count got=%0d required 1", nb);
        else if ({q[base].a, q[base].u, q[base].last} !== {24'h427579, 4'd8, 1'b1})
            $display("FAIL cr_word got=%h/%0d/%0b required 427579/8/1", q[base].a, q[base].u, q[base].last);
        else pass_cnt++;
`else
        total_cnt++;
        if (nb !== 2) begin
            $display("FAIL cr_count got=%0d required 2", nb);
            return;
        end
        pass_cnt++;
        total_cnt++;
        if ({q[base].a, q[base].u, q[base].last} !== {24'h427579, 4'd8, 1'b0})
            $display("FAIL cr_w0 got=%h/%0d/%0b required 427579/8/0", q[base].a, q[base].u, q[base].last);
        else pass_cnt++;
        total_cnt++;
        if ({q[base+1].a, q[base+1].u, q[base+1].last} !== {24'h0D2020, 4'd8, 1'b1})
            $display("FAIL cr_w1 got=%h/%0d/%0b required 0d2020/8/1", q[base+1].a, q[base+1].u, q[base+1].last);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_login();
        test_boundary();
        test_overflow();
        test_hold();
        test_reset_mid_emit();
        test_cr();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/shop_cmd_framer.md
Name: shop_cmd_framer

Overview:
- Upstream stage of the shop command processor.
- Accepts an ASCII byte stream, one command line at a time, terminated by LF (8'h0A).
- Packs each line into 24-bit, 3-character words, MSB-first.
- Emits the words to the shop core as consecutive one-cycle i_rdy/i_u/i_a beats, tagged with the line's user ID.
- Buffers one line, with overflow detection and downstream hold.

Parameters:
- O_A_NUM_BITS, 24, output word width; must be a multiple of 8 (chars per word = O_A_NUM_BITS/8).
- O_U_NUM_BITS, 4, user-ID width.
- MAX_WORDS, 4, maximum words per buffered line.
- PAD_CHAR, 8'h20, fill character for a partial final word.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  byte strobe; byte accepted when i_valid && o_ready.
- i_byte  in  8  ASCII character.
- i_uid  in  O_U_NUM_BITS  user ID; sampled with the first accepted byte of a line.
- i_hold  in  1  downstream stall; no beat is issued while high.
- o_ready  out  1  framer can accept a byte.
- o_rdy  out  1  word-valid strobe to the shop core.
- o_u  out  O_U_NUM_BITS  user ID of the current line.
- o_a  out  O_A_NUM_BITS  packed 3-char word.
- o_last  out  1  high with o_rdy on the final word of a line.
- o_err  out  1  one-cycle pulse when an overflowed line is dropped.

Behaviour:
- Reset (i_reset=0, async):
  - state=IDLE; all outputs 0; o_ready=0 while reset is asserted.
  - Word buffer, char counter and word counter cleared.
  - Reset asserted mid-line or mid-emit discards the line; nothing partial is emitted afterwards.
- State IDLE (o_ready=1):
  - Accepted LF: ignored (empty line, no beats).
  - Accepted other byte: latch i_uid, store char at position 0, go to COLLECT.
- State COLLECT (o_ready=1):
  - Each accepted non-LF byte goes to the next char slot of the current word, MSB-first.
  - When a word fills, it is written to buffer[wcnt] and wcnt increments.
  - If a byte arrives when wcnt==MAX_WORDS: go to DROP, flag overflow.
  - Accepted LF:
    - Any partial word is filled with PAD_CHAR in the remaining low slots and stored.
    - Go to EMIT; a line ending exactly on a word boundary emits no pad word.
- State DROP (o_ready=1):
  - Bytes are discarded until LF.
  - On LF: o_err=1 for exactly the next cycle, counters cleared, go to IDLE; no beats for that line.
- State EMIT (o_ready=0):
  - Each cycle with i_hold=0: o_rdy=1, o_a=buffer[idx], o_u=latched uid, o_last=(idx==wcnt-1); idx increments.
  - With i_hold=1: o_rdy=0, idx held; o_a/o_u hold their last driven value.
  - After the o_last beat: counters cleared, go to IDLE; o_ready=1 in the following cycle.
- Timing and latency:
  - LF accepted in cycle N → first beat in cycle N+1 (if i_hold=0).
  - Words are issued back-to-back; a W-word line occupies W cycles of EMIT.
- Output registering:
  - o_rdy, o_last and o_err are registered.
  - o_a, o_u and o_last are meaningful only while o_rdy=1.
- Counter widths:
  - Char counter: clog2(O_A_NUM_BITS/8).
  - wcnt/idx: clog2(MAX_WORDS+1); no wrap beyond MAX_WORDS.
- Input rules:
  - i_valid while o_ready=0: the byte is not accepted; the source must hold it.
  - i_uid changes mid-line are ignored.

Optional Feature:
- SHOP_FRAMER_CR_STRIP_EN
- Defined: accepted bytes equal to 8'h0D are consumed and discarded in every state (CRLF lines frame identically to LF lines); they never occupy a char slot.
- Undefined: 8'h0D is an ordinary character, packed like any other.

Test Plan:
1. Login line: reset low→high, uid=2, send "Login\n" → two beats:
   - o_a=24'h4C6F67, o_u=2, o_last=0;
   - then o_a=24'h696E20, o_last=1;
   - first beat the cycle after LF; no o_err.
2. Boundary and empty lines: send "Buy\n", then "\n" → exactly one beat o_a=24'h427579, o_last=1, no pad word; the empty line produces no beats.
3. Overflow: MAX_WORDS=4, send "AddItemAddItem\n" (14 chars) → zero beats, o_err pulses once the cycle after LF; a following "Adm\n" emits o_a=24'h41646D normally.
4. Hold: "DelUsr\n" with i_hold=1 for 3 cycles after LF → no o_rdy during hold; on release, 24'h44656C then 24'h557372 (o_last=1) on consecutive cycles; o_ready stays 0 throughout.
5. Reset mid-emit: assert i_reset=0 between the two beats of "Logout\n" → all outputs 0 immediately; after release, no remaining beat appears; o_ready=1.
6. CR handling: send "Buy\r\n" → with SHOP_FRAMER_CR_STRIP_EN, a single beat 24'h427579; without it, 24'h427579 then 24'h0D2020 (o_last=1).
